// File: rtl/player_multishot.sv
// player_multishot: ship column plus a pool of independent player bullets.
// Includes fire cooldown, per-slot hit clearing and saturating movement.
module player_multishot #(
    parameter int X_WIDTH        = 5,
    parameter int Y_WIDTH        = 4,
    parameter int X_MAX          = 19,
    parameter int SHIP_X_RESET   = 9,
    parameter int Y_START        = 14,
    parameter int NUM_BULLETS    = 3,
    parameter int STEP_TICKS     = 1250000,
    parameter int COOLDOWN_TICKS = 5000000
) (
    input  logic                           i_clk_25MHz,
    input  logic                           i_reset_n,
    input  logic                           i_left,
    input  logic                           i_right,
    input  logic                           i_shoot,
    input  logic [NUM_BULLETS-1:0]         i_hit,
    output logic [X_WIDTH-1:0]             o_ship_x,
    output logic [NUM_BULLETS*X_WIDTH-1:0] o_bullet_x,
    output logic [NUM_BULLETS*Y_WIDTH-1:0] o_bullet_y,
    output logic [NUM_BULLETS-1:0]         o_bullet_active,
    output logic                           o_fire
);
    localparam int STEP_W  = STEP_TICKS > 1 ? $clog2(STEP_TICKS) : 1;
    localparam int CD_W    = COOLDOWN_TICKS > 1 ? $clog2(COOLDOWN_TICKS) : 1;
    localparam int CD_LOAD = COOLDOWN_TICKS > 0 ? COOLDOWN_TICKS - 1 : 0;

    logic [X_WIDTH-1:0]                    ship_q, ship_d;
    logic [NUM_BULLETS-1:0][X_WIDTH-1:0]   bx_q, bx_d;
    logic [NUM_BULLETS-1:0][Y_WIDTH-1:0]   by_q, by_d;
    logic [NUM_BULLETS-1:0]                act_q, act_d, alloc;
    logic [STEP_W-1:0]                     step_q, step_d;
    logic [CD_W-1:0]                       cd_q, cd_d;
    logic                                  fire_q, fire_d, step, accept;

    always_comb begin
        step   = step_q == STEP_W'(STEP_TICKS - 1);
        step_d = step ? '0 : step_q + 1'b1;
        // isolates the lowest clear bit of the registered active mask
        alloc  = ~act_q & (act_q + NUM_BULLETS'(1));
        accept = i_shoot && cd_q == '0 && !(&act_q);
        fire_d = accept;
        cd_d   = accept ? CD_W'(CD_LOAD) : (cd_q != '0 ? cd_q - 1'b1 : cd_q);
        ship_d = ship_q;
        if (i_left && !i_right && ship_q != '0)
            ship_d = ship_q - 1'b1;
        else if (i_right && !i_left && ship_q < X_WIDTH'(X_MAX))
            ship_d = ship_q + 1'b1;
        act_d = act_q;
        bx_d  = bx_q;
        by_d  = by_q;
        for (int k = 0; k < NUM_BULLETS; k++) begin
            if (i_hit[k] && act_q[k]) begin
                act_d[k] = 1'b0;
                bx_d[k]  = '0;
                by_d[k]  = '0;
            end else if (accept && alloc[k]) begin
                act_d[k] = 1'b1;
                bx_d[k]  = ship_q;
                by_d[k]  = Y_WIDTH'(Y_START);
            end else if (act_q[k] && step) begin
                act_d[k] = by_q[k] != '0;
                bx_d[k]  = by_q[k] != '0 ? bx_q[k] : '0;
                by_d[k]  = by_q[k] != '0 ? by_q[k] - 1'b1 : '0;
            end
        end
    end

    always_ff @(posedge i_clk_25MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ship_q <= X_WIDTH'(SHIP_X_RESET);
            bx_q   <= '0;
            by_q   <= '0;
            act_q  <= '0;
            step_q <= '0;
            cd_q   <= '0;
            fire_q <= 1'b0;
        end else begin
            ship_q <= ship_d;
            bx_q   <= bx_d;
            by_q   <= by_d;
            act_q  <= act_d;
            step_q <= step_d;
            cd_q   <= cd_d;
            fire_q <= fire_d;
        end
    end

    assign o_ship_x        = ship_q;
    assign o_bullet_x      = bx_q;
    assign o_bullet_y      = by_q;
    assign o_bullet_active = act_q;
    assign o_fire          = fire_q;
endmodule

// File: tb/tb_player_multishot.sv
// tb_player_multishot: directed tables and sequences plus randomized traffic
// compared against a cycle-level reference model of the ship/bullet rules.
module tb_player_multishot;
    localparam int XW = 5, YW = 4, N = 3, ST = 4, CD = 10;
    localparam int XMAX = 19, XRST = 9, YST = 14;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          left = 1'b0, right = 1'b0, shoot = 1'b0;
    logic [N-1:0]  hit = '0;
    logic [XW-1:0] ship_x;
    logic [N*XW-1:0] bullet_x;
    logic [N*YW-1:0] bullet_y;
    logic [N-1:0]  active;
    logic          fire;

    player_multishot #(
        .X_WIDTH(XW), .Y_WIDTH(YW), .X_MAX(XMAX), .SHIP_X_RESET(XRST), .Y_START(YST),
        .NUM_BULLETS(N), .STEP_TICKS(ST), .COOLDOWN_TICKS(CD)
    ) dut (
        .i_clk_25MHz(clk), .i_reset_n(rst_n), .i_left(left), .i_right(right),
        .i_shoot(shoot), .i_hit(hit), .o_ship_x(ship_x), .o_bullet_x(bullet_x),
        .o_bullet_y(bullet_y), .o_bullet_active(active), .o_fire(fire)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    int m_ship, m_step, m_cd, m_fire;
    int m_act[N], m_x[N], m_y[N];

    typedef struct {
        logic l, r, s;
        logic [N-1:0] h;
        int ship;
        logic [N-1:0] act;
        logic f;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_ship = XRST; m_step = 0; m_cd = 0; m_fire = 0;
        for (int k = 0; k < N; k++) begin m_act[k] = 0; m_x[k] = 0; m_y[k] = 0; end
    endtask

    // one clock of the game rules, using the inputs present at this edge
    task automatic model_step();
        int stp, acc, slot;
        int na[N], nx[N], ny[N];
        stp = (m_step == ST - 1);
        slot = -1;
        for (int k = 0; k < N; k++) if (m_act[k] == 0 && slot < 0) slot = k;
        acc = (shoot && m_cd == 0 && slot >= 0);
        for (int k = 0; k < N; k++) begin
            na[k] = m_act[k]; nx[k] = m_x[k]; ny[k] = m_y[k];
            if (hit[k] && m_act[k] != 0) begin
                na[k] = 0; nx[k] = 0; ny[k] = 0;
            end else if (acc && k == slot) begin
                na[k] = 1; nx[k] = m_ship; ny[k] = YST;
            end else if (m_act[k] != 0 && stp) begin
                if (m_y[k] == 0) begin na[k] = 0; nx[k] = 0; ny[k] = 0; end
                else ny[k] = m_y[k] - 1;
            end
        end
        for (int k = 0; k < N; k++) begin m_act[k] = na[k]; m_x[k] = nx[k]; m_y[k] = ny[k]; end
        m_cd = acc ? CD - 1 : (m_cd > 0 ? m_cd - 1 : 0);
        m_step = stp ? 0 : m_step + 1;
        m_fire = acc;
        if (left && !right) m_ship = m_ship > 0 ? m_ship - 1 : 0;
        else if (right && !left) m_ship = m_ship < XMAX ? m_ship + 1 : XMAX;
    endtask

    function automatic logic [N*XW-1:0] pack_x();
        logic [N*XW-1:0] v = '0;
        for (int k = 0; k < N; k++) v[k*XW +: XW] = XW'(m_x[k]);
        return v;
    endfunction

    function automatic logic [N*YW-1:0] pack_y();
        logic [N*YW-1:0] v = '0;
        for (int k = 0; k < N; k++) v[k*YW +: YW] = YW'(m_y[k]);
        return v;
    endfunction

    function automatic logic [N-1:0] pack_a();
        logic [N-1:0] v = '0;
        for (int k = 0; k < N; k++) v[k] = m_act[k] != 0;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_ship", 32'(ship_x), 32'(m_ship));
        check("model_bx", 32'(bullet_x), 32'(pack_x()));
        check("model_by", 32'(bullet_y), 32'(pack_y()));
        check("model_act", 32'(active), 32'(pack_a()));
        check("model_fire", 32'(fire), 32'(m_fire));
    endtask

    task automatic do_reset();
        left = 0; right = 0; shoot = 0; hit = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("rst_ship", 32'(ship_x), XRST);
        check("rst_act", 32'(active), 0);
        check("rst_bx", 32'(bullet_x), 0);
        check("rst_by", 32'(bullet_y), 0);
        check("rst_fire", 32'(fire), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int fires[8];
        int nf, decs, prev_y, seen_zero, ey0, ey2;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 3'b000, 8,  3'b000, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 3'b000, 9,  3'b000, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 3'b000, 9,  3'b000, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 3'b000, 9,  3'b000, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 3'b000, 9,  3'b001, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 3'b000, 9,  3'b001, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 3'b000, 10, 3'b001, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 3'b001, 9,  3'b000, 1'b0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            left = tbl[i].l; right = tbl[i].r; shoot = tbl[i].s; hit = tbl[i].h;
            tick();
            check($sformatf("tbl%0d_ship", i), 32'(ship_x), 32'(tbl[i].ship));
            check($sformatf("tbl%0d_act", i), 32'(active), 32'(tbl[i].act));
            check($sformatf("tbl%0d_fire", i), 32'(fire), 32'(tbl[i].f));
        end

        // saturation at both edges
        do_reset();
        left = 1;
        repeat (9) tick();
        check("sat_left", 32'(ship_x), 0);
        tick();
        check("sat_left_hold", 32'(ship_x), 0);
        left = 0; right = 1;
        repeat (30) tick();
        check("sat_right", 32'(ship_x), XMAX);
        left = 1;
        tick();
        check("both_hold", 32'(ship_x), XMAX);
        left = 0; right = 0;

        // single bullet full flight
        do_reset();
        shoot = 1;
        tick();
        shoot = 0;
        check("launch_fire", 32'(fire), 1);
        check("launch_x", 32'(bullet_x[XW-1:0]), XRST);
        check("launch_y", 32'(bullet_y[YW-1:0]), YST);
        check("launch_act", 32'(active), 3'b001);
        decs = 0; seen_zero = 0; prev_y = YST;
        for (int i = 0; i < 100 && active[0]; i++) begin
            tick();
            if (active[0] && int'(bullet_y[YW-1:0]) != prev_y) decs++;
            if (active[0] && bullet_y[YW-1:0] == 0) seen_zero = 1;
            prev_y = int'(bullet_y[YW-1:0]);
        end
        check("flight_decs", 32'(decs), 14);
        check("flight_zero", 32'(seen_zero), 1);
        check("flight_done", 32'(active[0]), 0);

        // pool fill under cooldown
        do_reset();
        shoot = 1; nf = 0;
        for (int c = 1; c <= 35; c++) begin
            tick();
            if (fire && nf < 8) begin fires[nf] = c; nf++; end
        end
        shoot = 0;
        check("pool_nfires", 32'(nf), 3);
        check("pool_fire0", 32'(fires[0]), 1);
        check("pool_fire1", 32'(fires[1]), 11);
        check("pool_fire2", 32'(fires[2]), 21);
        check("pool_full", 32'(active), 3'b111);

        // hit coinciding with a step strobe
        for (int i = 0; i < 8 && m_step != ST - 1; i++) tick();
        ey0 = m_y[0] - 1; ey2 = m_y[2] - 1;
        hit = 3'b010;
        tick();
        hit = '0;
        check("hitstep_act", 32'(active), 3'b101);
        check("hitstep_y0", 32'(bullet_y[0 +: YW]), 32'(ey0));
        check("hitstep_y1", 32'(bullet_y[YW +: YW]), 0);
        check("hitstep_y2", 32'(bullet_y[2*YW +: YW]), 32'(ey2));
        shoot = 1;
        tick();
        shoot = 0;
        check("refill_fire", 32'(fire), 1);
        check("refill_act", 32'(active), 3'b111);
        repeat (10) tick();
        hit = 3'b001; shoot = 1;
        tick();
        hit = '0;
        check("hitfull_act0", 32'(active[0]), 0);
        check("hitfull_fire", 32'(fire), 0);
        tick();
        shoot = 0;
        check("relaunch_fire", 32'(fire), 1);
        check("relaunch_act", 32'(active), 3'b111);
        check("relaunch_y0", 32'(bullet_y[0 +: YW]), YST);

        // launch uses pre-move ship column
        do_reset();
        left = 1;
        repeat (4) tick();
        left = 0;
        check("pre_ship", 32'(ship_x), 5);
        shoot = 1; right = 1;
        tick();
        shoot = 0; right = 0;
        check("move_bx", 32'(bullet_x[XW-1:0]), 5);
        check("move_ship", 32'(ship_x), 6);

        // asynchronous reset with a bullet in flight
        left = 1;
        tick();
        left = 0; shoot = 0;
        repeat (3) tick();
        #3 rst_n = 1'b0;
        #1;
        check("arst_ship", 32'(ship_x), XRST);
        check("arst_act", 32'(active), 0);
        check("arst_bx", 32'(bullet_x), 0);
        check("arst_by", 32'(bullet_y), 0);
        model_reset();
        #1 rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            left  = $urandom_range(0, 3) == 0;
            right = $urandom_range(0, 3) == 0;
            shoot = $urandom_range(0, 2) == 0;
            hit   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            tick();
        end
        left = 0; right = 0; shoot = 0; hit = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/player_multishot.md
Name: player_multishot

Overview:
Parametrised successor to the single-bullet player datapath. Tracks the ship column and a pool of NUM_BULLETS independent player bullets. Supports fire cooldown, per-bullet hit clearing and saturating ship movement. Sits between the three edge_detector_debouncer instances in the top level and the renderer/collision logic; all inputs are already-debounced single-cycle pulses.

Parameters:
X_WIDTH, 5, width of ship and bullet column coordinates
Y_WIDTH, 4, width of bullet row coordinate
X_MAX, 19, rightmost legal ship column (must be < 2^X_WIDTH)
SHIP_X_RESET, 9, ship column after reset
Y_START, 14, row a new bullet is loaded at (row above ship)
NUM_BULLETS, 3, bullet slots (1..8)
STEP_TICKS, 1250000, clock cycles per bullet row step (50 ms at 25 MHz)
COOLDOWN_TICKS, 5000000, cycles after a fire during which shoot is ignored

Ports:
i_clk_25MHz  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_left  input  1  debounced pulse, move ship one column left
i_right  input  1  debounced pulse, move ship one column right
i_shoot  input  1  debounced pulse, fire request
i_hit  input  NUM_BULLETS  per-slot hit pulse from collision logic, bit k = slot k
o_ship_x  output  X_WIDTH  current ship column
o_bullet_x  output  NUM_BULLETS*X_WIDTH  packed slot columns, slot k at [k*X_WIDTH +: X_WIDTH]
o_bullet_y  output  NUM_BULLETS*Y_WIDTH  packed slot rows, same packing
o_bullet_active  output  NUM_BULLETS  slot k in flight
o_fire  output  1  one-cycle pulse when a bullet is launched (sound trigger)

Behaviour:
- Clocking: single clock; reset is asynchronous, active-low. All outputs registered; input in cycle k is visible on outputs in cycle k+1.
- Reset values:
  - o_ship_x = SHIP_X_RESET; all slots inactive with x=0, y=0; o_fire=0.
  - Step counter = 0; cooldown counter = 0.
- Reset deassertion mid-flight restarts from the reset state; no bullet survives reset.
- Ship movement:
  - i_left alone: x-1, saturate at 0. i_right alone: x+1, saturate at X_MAX.
  - Both together or neither: no change.
- Step counter: free-running 0..STEP_TICKS-1. The "step" strobe fires on the cycle the counter equals STEP_TICKS-1, then it wraps to 0.
- Per-slot update, priority highest first:
  1. Hit: i_hit[k]=1 and slot active -> slot inactive, x=0, y=0. A hit on an inactive slot is ignored.
  2. Launch: slot k is the allocated slot -> active, x=o_ship_x (pre-move value of that cycle), y=Y_START. No decrement in the launch cycle even if step fires.
  3. Step: slot active and step strobe -> if y=0, slot inactive and x,y cleared (left top of screen); else y-1.
  4. Otherwise hold.
- Fire allocation:
  - Request accepted when i_shoot=1, cooldown=0 and at least one slot has registered active=0.
  - Allocated slot = lowest-index free slot.
  - A slot freed by i_hit in the same cycle does not count as free until the next cycle.
  - Rejected requests are dropped, not queued.
- On accept: o_fire=1 for one cycle; cooldown loaded with COOLDOWN_TICKS-1. Cooldown then decrements by 1 per cycle to 0. COOLDOWN_TICKS=0 disables cooldown.
- Widths: counters sized by $clog2 of their maximum. Coordinate arithmetic never wraps; saturation at boundaries as above.

Test Plan:
- Reset: hold i_reset_n=0 for 3 cycles, release -> o_ship_x=9, o_bullet_active=000, o_bullet_x/y all 0, o_fire=0. Assert reset asynchronously mid-cycle with bullets in flight -> outputs clear without waiting for a clock edge.
- Movement saturation: from x=9, 9 i_left pulses -> o_ship_x=0 after the 9th; 30 i_right pulses -> o_ship_x=19. i_left and i_right in the same cycle -> no change.
- Launch and flight (STEP_TICKS=4, COOLDOWN_TICKS=0): ship at 9, i_shoot -> next cycle slot0 active, x=9, y=14, o_fire=1. y reaches 0 after 14 steps. On the 15th step slot0 goes inactive.
- Pool and cooldown (COOLDOWN_TICKS=10):
  - Shoot every cycle -> launches 10 cycles apart into slots 0, 1, 2.
  - 4th accepted-time request with all slots busy -> no launch, o_fire=0.
  - Shoot at cycle 3 after a launch -> ignored.
- Hit priority: i_hit=010 on the same cycle as a step strobe -> slot1 cleared, slots 0 and 2 decrement. i_hit=001 with i_shoot when all slots are full -> slot0 cleared, no launch that cycle; i_shoot next cycle launches into slot0.
- Launch during ship move: ship at 5, i_shoot and i_right in the same cycle -> bullet x=5, ship x=6.
